// File: rtl/controlador_ram64_pkg.sv
// rtl/controlador_ram64_pkg.sv - shared constants and encodings for the RAM64 front end
package pacote_ram64;

  localparam int LARGURA_DADOS = 16;
  localparam int LARGURA_END   = 6;
  localparam int PROFUNDIDADE  = 64;

  typedef enum logic {
    LIMPA = 1'b0,
    ATIVO = 1'b1
  } estado_t;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_t;

endpackage

// File: rtl/arbitro_rr2.sv
// rtl/arbitro_rr2.sv - two-way round-robin arbiter with one-hot grant
module arbitro_rr2 (
  input  logic       clock_principal,
  input  logic       reset,
  input  logic       habilita,
  input  logic       valido_a,
  input  logic       valido_b,
  output logic [1:0] concessao
);
  import pacote_ram64::*;

  prio_t ponteiro;

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    concessao = 2'b00;
    if (habilita) begin
      if (valido_a && (!valido_b || ponteiro == PRIO_A)) begin
        concessao = 2'b01;
      end else if (valido_b) begin
        concessao = 2'b10;
      end
    end
  end

  always_ff @(posedge clock_principal) begin
    if (reset) begin
      ponteiro <= PRIO_A;
    end else if (concessao[0]) begin
      ponteiro <= PRIO_B;
    end else if (concessao[1]) begin
      ponteiro <= PRIO_A;
    end
  end

endmodule

// File: rtl/controlador_ram64.sv
// rtl/controlador_ram64.sv - arbitrated two-requester front end with power-up clear for RAM64
module controlador_ram64 #(
  parameter int LARGURA_DADOS = 16,
  parameter int LARGURA_END   = 6,
  parameter int LIMPA_INICIAL = 1
) (
  input  logic                     clock_principal,
  input  logic                     reset,
  input  logic                     a_valido,
  input  logic                     a_escrita,
  input  logic [LARGURA_END-1:0]   a_endereco,
  input  logic [LARGURA_DADOS-1:0] a_dados,
  output logic                     a_pronto,
  output logic                     a_resp_valida,
  output logic [LARGURA_DADOS-1:0] a_resp_dados,
  input  logic                     b_valido,
  input  logic                     b_escrita,
  input  logic [LARGURA_END-1:0]   b_endereco,
  input  logic [LARGURA_DADOS-1:0] b_dados,
  output logic                     b_pronto,
  output logic                     b_resp_valida,
  output logic [LARGURA_DADOS-1:0] b_resp_dados,
  output logic                     ocupado,
  output logic [LARGURA_DADOS-1:0] ram_dados_entrada,
  output logic [LARGURA_END-1:0]   ram_endereco,
  output logic                     ram_write,
  input  logic [LARGURA_DADOS-1:0] ram_dados_saida
);
  import pacote_ram64::*;

  localparam logic [LARGURA_END-1:0] ULTIMO_END = LARGURA_END'(PROFUNDIDADE - 1);

  estado_t                estado, estado_prox;
  logic [LARGURA_END-1:0] contador, contador_prox;
  logic [1:0]             concessao;
  logic                   habilita;

  assign habilita = (estado == ATIVO) && !reset;

  arbitro_rr2 u_arbitro (
    .clock_principal (clock_principal),
    .reset           (reset),
    .habilita        (habilita),
    .valido_a        (a_valido),
    .valido_b        (b_valido),
    .concessao       (concessao)
  );

  assign a_pronto = concessao[0];
  assign b_pronto = concessao[1];

  always_comb begin
    estado_prox       = estado;
    contador_prox     = contador;
    ocupado           = 1'b0;
    ram_write         = 1'b0;
    ram_endereco      = '0;
    ram_dados_entrada = '0;
    case (estado)
      LIMPA: begin
        ocupado      = 1'b1;
        ram_write    = !reset;
        ram_endereco = contador;
        if (contador == ULTIMO_END) begin
          estado_prox = ATIVO;
        end else begin
          contador_prox = contador + 1'b1;
        end
      end
      ATIVO: begin
        if (concessao[0]) begin
          ram_endereco      = a_endereco;
          ram_dados_entrada = a_dados;
          ram_write         = a_escrita;
        end else if (concessao[1]) begin
          ram_endereco      = b_endereco;
          ram_dados_entrada = b_dados;
          ram_write         = b_escrita;
        end
      end
      default: estado_prox = ATIVO;
    endcase
  end

  always_ff @(posedge clock_principal) begin
    if (reset) begin
      estado   <= (LIMPA_INICIAL != 0) ? LIMPA : ATIVO;
      contador <= '0;
    end else begin
      estado   <= estado_prox;
      contador <= contador_prox;
    end
  end

  // Writes are acknowledged with the data that was stored; reads return the RAM output.
  always_ff @(posedge clock_principal) begin
    if (reset) begin
      a_resp_valida <= 1'b0;
      b_resp_valida <= 1'b0;
      a_resp_dados  <= '0;
      b_resp_dados  <= '0;
    end else begin
      a_resp_valida <= concessao[0];
      b_resp_valida <= concessao[1];
      if (concessao[0]) begin
        a_resp_dados <= a_escrita ? a_dados : ram_dados_saida;
      end
      if (concessao[1]) begin
        b_resp_dados <= b_escrita ? b_dados : ram_dados_saida;
      end
    end
  end

endmodule

// File: tb/tb_controlador_ram64.sv
// tb/tb_controlador_ram64.sv - directed self-checking bench for controlador_ram64
module tb_controlador_ram64;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valido, a_escrita, b_valido, b_escrita;
  logic [5:0]  a_endereco, b_endereco;
  logic [15:0] a_dados, b_dados;
  logic        a_pronto, b_pronto, a_resp_valida, b_resp_valida, ocupado, ram_write;
  logic [15:0] a_resp_dados, b_resp_dados, ram_dados_entrada, ram_dados_saida;
  logic [5:0]  ram_endereco;

  logic [15:0] mem [64];
  logic        tb_wr;
  logic [5:0]  tb_end;
  logic [15:0] tb_dado;

  int comparados = 0;
  int erros = 0;

  always #5 clk = ~clk;

  controlador_ram64 dut (
    .clock_principal   (clk),
    .reset             (reset),
    .a_valido          (a_valido),
    .a_escrita         (a_escrita),
    .a_endereco        (a_endereco),
    .a_dados           (a_dados),
    .a_pronto          (a_pronto),
    .a_resp_valida     (a_resp_valida),
    .a_resp_dados      (a_resp_dados),
    .b_valido          (b_valido),
    .b_escrita         (b_escrita),
    .b_endereco        (b_endereco),
    .b_dados           (b_dados),
    .b_pronto          (b_pronto),
    .b_resp_valida     (b_resp_valida),
    .b_resp_dados      (b_resp_dados),
    .ocupado           (ocupado),
    .ram_dados_entrada (ram_dados_entrada),
    .ram_endereco      (ram_endereco),
    .ram_write         (ram_write),
    .ram_dados_saida   (ram_dados_saida)
  );

  // Behavioural RAM64: combinational read, write on rising edge; side port for preloading.
  assign ram_dados_saida = mem[ram_endereco];
  always @(posedge clk) begin
    if (ram_write) mem[ram_endereco] <= ram_dados_entrada;
    else if (tb_wr) mem[tb_end] <= tb_dado;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic w, input logic [5:0] e, input logic [15:0] d);
    a_valido = v; a_escrita = w; a_endereco = e; a_dados = d;
  endtask

  task automatic drive_b(input logic v, input logic w, input logic [5:0] e, input logic [15:0] d);
    b_valido = v; b_escrita = w; b_endereco = e; b_dados = d;
  endtask

  task automatic preload(input logic [5:0] e, input logic [15:0] d);
    tb_wr = 1'b1; tb_end = e; tb_dado = d;
    step();
    tb_wr = 1'b0;
  endtask

  task automatic reset_and_clear;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    repeat (64) step();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int i = 0; i < 64; i++) preload(6'(i), 16'hDEAD);
    @(negedge clk);
    comparados++; if (ram_write !== 1'b0) begin erros++; $display("FAIL rst_ram_write: got %0b exp 0", ram_write); end
    comparados++; if ({a_pronto, b_pronto} !== 2'b00) begin erros++; $display("FAIL rst_pronto: got %b exp 00", {a_pronto, b_pronto}); end
    comparados++; if ({a_resp_valida, b_resp_valida} !== 2'b00) begin erros++; $display("FAIL rst_resp_valida: got %b exp 00", {a_resp_valida, b_resp_valida}); end
    comparados++; if ({a_resp_dados, b_resp_dados} !== 32'h0) begin erros++; $display("FAIL rst_resp_dados: got %h exp 0", {a_resp_dados, b_resp_dados}); end
    comparados++; if (ocupado !== 1'b1) begin erros++; $display("FAIL rst_ocupado: got %0b exp 1", ocupado); end
    step();
    reset = 1'b0;
  endtask

  task automatic test_clear;
    int nz;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      comparados++;
      if ({ocupado, ram_write, ram_endereco, ram_dados_entrada} !== {1'b1, 1'b1, 6'(i), 16'h0000}) begin
        erros++;
        $display("FAIL clear_cycle%0d: got ocupado=%0b wr=%0b end=%0d dado=%h exp 1 1 %0d 0000",
                 i, ocupado, ram_write, ram_endereco, ram_dados_entrada, i);
      end
      step();
    end
    @(negedge clk);
    comparados++; if ({ocupado, ram_write} !== 2'b00) begin erros++; $display("FAIL clear_end: got ocupado/wr=%b exp 00", {ocupado, ram_write}); end
    nz = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== 16'h0000) nz++;
    comparados++; if (nz != 0) begin erros++; $display("FAIL clear_mem: got %0d nonzero words exp 0", nz); end
    step();
    drive_a(1'b1, 1'b0, 6'd63, 16'h0);
    @(negedge clk);
    comparados++; if (a_pronto !== 1'b1) begin erros++; $display("FAIL clear_rd63_pronto: got %0b exp 1", a_pronto); end
    step();
    drive_a(1'b0, 1'b0, 6'd0, 16'h0);
    @(negedge clk);
    comparados++; if ({a_resp_valida, a_resp_dados} !== {1'b1, 16'h0000}) begin erros++; $display("FAIL clear_rd63_resp: got %0b/%h exp 1/0000", a_resp_valida, a_resp_dados); end
    step();
  endtask

  task automatic test_write_read_a;
    drive_a(1'b1, 1'b1, 6'd0, 16'hAAAA);
    @(negedge clk);
    comparados++; if ({a_pronto, ram_write, ram_endereco, ram_dados_entrada} !== {1'b1, 1'b1, 6'd0, 16'hAAAA}) begin
      erros++; $display("FAIL wr_a_bus: got pronto=%0b wr=%0b end=%0d dado=%h exp 1 1 0 aaaa", a_pronto, ram_write, ram_endereco, ram_dados_entrada); end
    step();
    drive_a(1'b1, 1'b0, 6'd0, 16'h0);
    @(negedge clk);
    comparados++; if ({a_pronto, ram_write} !== 2'b10) begin erros++; $display("FAIL rd_a_pronto: got pronto/wr=%b exp 10", {a_pronto, ram_write}); end
    comparados++; if ({a_resp_valida, a_resp_dados} !== {1'b1, 16'hAAAA}) begin erros++; $display("FAIL wr_a_ack: got %0b/%h exp 1/aaaa", a_resp_valida, a_resp_dados); end
    step();
    drive_a(1'b0, 1'b0, 6'd0, 16'h0);
    @(negedge clk);
    comparados++; if ({a_resp_valida, a_resp_dados} !== {1'b1, 16'hAAAA}) begin erros++; $display("FAIL rd_a_resp: got %0b/%h exp 1/aaaa", a_resp_valida, a_resp_dados); end
    step();
    @(negedge clk);
    comparados++; if ({a_resp_valida, a_resp_dados} !== {1'b0, 16'hAAAA}) begin erros++; $display("FAIL rd_a_pulse_hold: got %0b/%h exp 0/aaaa", a_resp_valida, a_resp_dados); end
    step();
  endtask

  task automatic test_both_valid;
    drive_a(1'b1, 1'b1, 6'd5, 16'h1234);
    drive_b(1'b1, 1'b0, 6'd5, 16'h0);
    @(negedge clk);
    comparados++; if ({a_pronto, b_pronto} !== 2'b10) begin erros++; $display("FAIL both_c1_grant: got a/b=%b exp 10", {a_pronto, b_pronto}); end
    step();
    drive_a(1'b0, 1'b0, 6'd0, 16'h0);
    @(negedge clk);
    comparados++; if ({a_pronto, b_pronto, ram_write, ram_endereco} !== {2'b01, 1'b0, 6'd5}) begin
      erros++; $display("FAIL both_c2_grant: got a/b=%b wr=%0b end=%0d exp 01 0 5", {a_pronto, b_pronto}, ram_write, ram_endereco); end
    comparados++; if (a_resp_valida !== 1'b1) begin erros++; $display("FAIL both_c2_a_ack: got %0b exp 1", a_resp_valida); end
    step();
    drive_b(1'b0, 1'b0, 6'd0, 16'h0);
    @(negedge clk);
    comparados++; if ({b_resp_valida, b_resp_dados, a_resp_valida} !== {1'b1, 16'h1234, 1'b0}) begin
      erros++; $display("FAIL both_b_resp: got bv=%0b bd=%h av=%0b exp 1 1234 0", b_resp_valida, b_resp_dados, a_resp_valida); end
    step();
  endtask

  task automatic test_alternating;
    logic ea;
    preload(6'd1, 16'h0F0F);
    preload(6'd2, 16'hF0F0);
    drive_a(1'b1, 1'b0, 6'd1, 16'h0);
    drive_b(1'b1, 1'b0, 6'd2, 16'h0);
    for (int i = 0; i < 6; i++) begin
      ea = (i % 2 == 0);
      @(negedge clk);
      comparados++; if ({a_pronto, b_pronto} !== {ea, !ea}) begin erros++; $display("FAIL alt_grant%0d: got a/b=%b exp %b", i, {a_pronto, b_pronto}, {ea, !ea}); end
      if (i > 0) begin
        comparados++;
        if ({a_resp_valida, b_resp_valida} !== {!ea, ea} ||
            (ea ? b_resp_dados : a_resp_dados) !== (ea ? 16'hF0F0 : 16'h0F0F)) begin
          erros++; $display("FAIL alt_resp%0d: got av/bv=%b ad=%h bd=%h", i, {a_resp_valida, b_resp_valida}, a_resp_dados, b_resp_dados); end
      end
      step();
    end
    drive_a(1'b0, 1'b0, 6'd0, 16'h0);
    drive_b(1'b0, 1'b0, 6'd0, 16'h0);
    @(negedge clk);
    comparados++; if ({a_resp_valida, b_resp_valida, b_resp_dados} !== {2'b01, 16'hF0F0}) begin
      erros++; $display("FAIL alt_last: got av/bv=%b bd=%h exp 01 f0f0", {a_resp_valida, b_resp_valida}, b_resp_dados); end
    step();
  endtask

  task automatic test_only_b;
    preload(6'd63, 16'h5A5A);
    drive_b(1'b1, 1'b0, 6'd63, 16'h0);
    @(negedge clk);
    comparados++; if ({a_pronto, b_pronto, ram_endereco} !== {2'b01, 6'd63}) begin
      erros++; $display("FAIL only_b_grant: got a/b=%b end=%0d exp 01 63", {a_pronto, b_pronto}, ram_endereco); end
    step();
    drive_b(1'b0, 1'b0, 6'd0, 16'h0);
    @(negedge clk);
    comparados++; if ({b_resp_valida, b_resp_dados} !== {1'b1, 16'h5A5A}) begin erros++; $display("FAIL only_b_resp: got %0b/%h exp 1/5a5a", b_resp_valida, b_resp_dados); end
    step();
  endtask

  task automatic test_collision;
    drive_a(1'b1, 1'b1, 6'd7, 16'h1111);
    drive_b(1'b1, 1'b1, 6'd7, 16'h2222);
    @(negedge clk);
    comparados++; if ({a_pronto, b_pronto} !== 2'b10) begin erros++; $display("FAIL coll_c1: got a/b=%b exp 10", {a_pronto, b_pronto}); end
    step();
    drive_a(1'b0, 1'b0, 6'd0, 16'h0);
    @(negedge clk);
    comparados++; if ({b_pronto, ram_write, ram_dados_entrada} !== {2'b11, 16'h2222}) begin
      erros++; $display("FAIL coll_c2: got bp=%0b wr=%0b dado=%h exp 1 1 2222", b_pronto, ram_write, ram_dados_entrada); end
    step();
    drive_b(1'b0, 1'b0, 6'd0, 16'h0);
    drive_a(1'b1, 1'b0, 6'd7, 16'h0);
    step();
    drive_a(1'b0, 1'b0, 6'd0, 16'h0);
    @(negedge clk);
    comparados++; if ({a_resp_valida, a_resp_dados} !== {1'b1, 16'h2222}) begin erros++; $display("FAIL coll_raw: got %0b/%h exp 1/2222", a_resp_valida, a_resp_dados); end
    step();
  endtask

  task automatic test_reset_mid_clear;
    int n;
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (20) step();
    comparados++; if (ram_endereco !== 6'd20) begin erros++; $display("FAIL mid_count20: got %0d exp 20", ram_endereco); end
    reset = 1'b1;
    @(negedge clk);
    comparados++; if (ram_write !== 1'b0) begin erros++; $display("FAIL mid_rst_wr: got %0b exp 0", ram_write); end
    step();
    reset = 1'b0;
    @(negedge clk);
    comparados++; if (ram_endereco !== 6'd0) begin erros++; $display("FAIL mid_restart: got %0d exp 0", ram_endereco); end
    n = 0;
    while (ocupado === 1'b1 && n < 100) begin
      n++;
      step();
      @(negedge clk);
    end
    comparados++; if (n != 64) begin erros++; $display("FAIL mid_ocupado_len: got %0d exp 64", n); end
    step();
  endtask

  task automatic test_reset_during_read;
    drive_a(1'b1, 1'b0, 6'd0, 16'h0);
    reset = 1'b1;
    @(negedge clk);
    comparados++; if ({a_pronto, ram_write} !== 2'b00) begin erros++; $display("FAIL rdrst_pronto: got pronto/wr=%b exp 00", {a_pronto, ram_write}); end
    step();
    drive_a(1'b0, 1'b0, 6'd0, 16'h0);
    @(negedge clk);
    comparados++; if ({a_resp_valida, a_resp_dados, ocupado} !== {1'b0, 16'h0000, 1'b1}) begin
      erros++; $display("FAIL rdrst_resp: got av=%0b ad=%h ocupado=%0b exp 0 0000 1", a_resp_valida, a_resp_dados, ocupado); end
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    tb_wr = 1'b0; tb_end = '0; tb_dado = '0;
    drive_a(1'b0, 1'b0, 6'd0, 16'h0);
    drive_b(1'b0, 1'b0, 6'd0, 16'h0);
    step();
    test_reset();
    test_clear();
    test_write_read_a();
    reset_and_clear();
    test_both_valid();
    test_alternating();
    test_only_b();
    test_collision();
    test_reset_mid_clear();
    test_reset_during_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparados, erros);
    $finish;
  end

endmodule
